// File: rtl/b_fetch_unit_if.sv
// Fetch-unit bundle: redirect requests, instruction-memory handshake and fetch status.
// The master modport is the fetch unit; the slave modport is its environment.
interface b_fetch_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 6,
    parameter int unsigned IMM_W = 16,
    parameter int unsigned CNT_W = 16
);
    logic                  stall;
    logic                  br_taken;
    logic [IMM_W-1:0]      br_off;
    logic                  jump;
    logic [WIDTH-OP_W-1:0] jump_imm;
    logic                  jump_reg;
    logic [WIDTH-1:0]      reg_target;
    logic                  imem_ready;
    logic                  imem_req;
    logic [WIDTH-1:0]      pc;
    logic [WIDTH-1:0]      pc_plus4;
    logic                  redir_pend;
    logic [CNT_W-1:0]      fetch_cnt;

    modport master (
        input  stall, br_taken, br_off, jump, jump_imm, jump_reg, reg_target, imem_ready,
        output imem_req, pc, pc_plus4, redir_pend, fetch_cnt
    );

    modport slave (
        output stall, br_taken, br_off, jump, jump_imm, jump_reg, reg_target, imem_ready,
        input  imem_req, pc, pc_plus4, redir_pend, fetch_cnt
    );
endinterface

// File: rtl/b_fetch_unit.sv
// Instruction fetch PC unit: sequential fetch, prioritised redirects, redirect latching
// under backpressure and a saturating count of accepted fetches.
module b_fetch_unit #(
    parameter int unsigned           WIDTH     = 32,
    parameter int unsigned           OP_W      = 6,
    parameter int unsigned           IMM_W     = 16,
    parameter logic [WIDTH-1:0]      RESET_VEC = '0,
    parameter int unsigned           CNT_W     = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    b_fetch_unit_if.master bus_io
);

    typedef enum logic [0:0] {StBoot, StFetch} state_e;

    localparam logic [WIDTH-1:0] PcStep = WIDTH'(4);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] jr_tgt, jump_tgt, br_tgt, br_disp, redir_tgt;
    logic             redir_req;
    logic             accept;

    assign pc_plus4 = pc_q + PcStep;

    // Word-aligned targets; the branch offset counts words, hence the two zero LSBs.
    assign jr_tgt   = {bus_io.reg_target[WIDTH-1:2], 2'b00};
    assign jump_tgt = {pc_plus4[WIDTH-1:WIDTH-OP_W+2], bus_io.jump_imm, 2'b00};
    assign br_disp  = {{(WIDTH-IMM_W-2){bus_io.br_off[IMM_W-1]}}, bus_io.br_off, 2'b00};
    assign br_tgt   = pc_plus4 + br_disp;

    assign redir_req = bus_io.jump_reg | bus_io.jump | bus_io.br_taken;

    always_comb begin
        redir_tgt = br_tgt;
        if (bus_io.jump_reg) begin
            redir_tgt = jr_tgt;
        end else if (bus_io.jump) begin
            redir_tgt = jump_tgt;
        end
    end

    assign accept = (state_q == StFetch) & bus_io.imem_ready & ~bus_io.stall;

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StFetch;
            StFetch: state_d = StFetch;
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath next state: a same-cycle redirect beats a latched one, which beats pc+4.
    always_comb begin
        pc_d   = pc_q;
        tgt_d  = tgt_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        if (accept) begin
            if (redir_req) begin
                pc_d = redir_tgt;
            end else if (pend_q) begin
                pc_d = tgt_q;
            end else begin
                pc_d = pc_plus4;
            end
            pend_d = 1'b0;
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (redir_req) begin
            tgt_d  = redir_tgt;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q   <= RESET_VEC;
            tgt_q  <= '0;
            pend_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            tgt_q  <= tgt_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus_io.imem_req   = (state_q == StFetch);
    assign bus_io.pc         = pc_q;
    assign bus_io.pc_plus4   = pc_plus4;
    assign bus_io.redir_pend = pend_q;
    assign bus_io.fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_b_fetch_unit.sv
// Self-checking bench for b_fetch_unit: a reference model pushes expected state into a
// scoreboard as each cycle is driven; the scenario tasks pop and compare after the edge.
module tb_b_fetch_unit;

    logic clk;
    logic rst_n;
    logic rst2_n;

    b_fetch_unit_if #(.WIDTH(32), .OP_W(6), .IMM_W(16), .CNT_W(16)) u_if ();
    b_fetch_unit_if #(.WIDTH(32), .OP_W(6), .IMM_W(16), .CNT_W(2))  u_if2 ();

    b_fetch_unit #(
        .WIDTH(32), .OP_W(6), .IMM_W(16), .RESET_VEC(32'h0), .CNT_W(16)
    ) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (u_if.master)
    );

    b_fetch_unit #(
        .WIDTH(32), .OP_W(6), .IMM_W(16), .RESET_VEC(32'h0), .CNT_W(2)
    ) u_dut_sat (
        .clk_i  (clk),
        .rst_ni (rst2_n),
        .bus_io (u_if2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   sb2_q[$];
    int   checks;
    int   failures;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    logic        m_pend;
    logic [15:0] m_cnt;
    logic        m_fetch;

    task automatic model_reset();
        m_pc    = 32'h0;
        m_tgt   = 32'h0;
        m_pend  = 1'b0;
        m_cnt   = 16'h0;
        m_fetch = 1'b0;
        sb_q.delete();
    endtask

    task automatic set_idle();
        u_if.stall      = 1'b0;
        u_if.imem_ready = 1'b1;
        u_if.jump_reg   = 1'b0;
        u_if.reg_target = 32'h0;
        u_if.jump       = 1'b0;
        u_if.jump_imm   = 26'h0;
        u_if.br_taken   = 1'b0;
        u_if.br_off     = 16'h0;
    endtask

    // Drives one cycle, pushes the modelled post-edge state, then waits to 1 ns after the edge.
    task automatic drive_cycle(input logic st, input logic rdy, input logic jr,
                               input logic [31:0] rt, input logic j, input logic [25:0] ji,
                               input logic bt, input logic [15:0] bo);
        logic        acc;
        logic        req;
        logic [31:0] p4;
        logic [31:0] tgt;
        exp_t        e;
        u_if.stall      = st;
        u_if.imem_ready = rdy;
        u_if.jump_reg   = jr;
        u_if.reg_target = rt;
        u_if.jump       = j;
        u_if.jump_imm   = ji;
        u_if.br_taken   = bt;
        u_if.br_off     = bo;
        acc = m_fetch && rdy && !st;
        req = jr || j || bt;
        p4  = m_pc + 32'd4;
        if (jr)     tgt = rt & 32'hFFFF_FFFC;
        else if (j) tgt = {p4[31:28], ji, 2'b00};
        else        tgt = p4 + ({{16{bo[15]}}, bo} << 2);
        if (acc) begin
            if (req)         m_pc = tgt;
            else if (m_pend) m_pc = m_tgt;
            else             m_pc = p4;
            m_pend = 1'b0;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (req) begin
            m_tgt  = tgt;
            m_pend = 1'b1;
        end
        m_fetch = 1'b1;
        e.pc   = m_pc;
        e.pend = m_pend;
        e.cnt  = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        set_idle();
        model_reset();
        #3;
        checks++;
        if (u_if.imem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_req got=%b want=0", u_if.imem_req);
        end
        checks++;
        if (u_if.pc !== 32'h0 || u_if.redir_pend !== 1'b0 || u_if.fetch_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_state got pc=%h pend=%b cnt=%0d want pc=0 pend=0 cnt=0",
                     u_if.pc, u_if.redir_pend, u_if.fetch_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(0, 1, 0, 0, 0, 0, 0, 0);
        e = sb_q.pop_front();
        checks++;
        if (u_if.imem_req !== 1'b1) begin
            failures++;
            $display("FAIL boot_req got=%b want=1", u_if.imem_req);
        end
        checks++;
        if (u_if.pc !== e.pc) begin
            failures++;
            $display("FAIL boot_pc got=%h want=%h", u_if.pc, e.pc);
        end
    endtask

    task automatic test_sequential();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, 1, 0, 0, 0, 0, 0, 0);
            e = sb_q.pop_front();
            checks++;
            if (u_if.pc !== e.pc || u_if.fetch_cnt !== e.cnt) begin
                failures++;
                $display("FAIL seq_%0d got pc=%h cnt=%0d want pc=%h cnt=%0d",
                         i, u_if.pc, u_if.fetch_cnt, e.pc, e.cnt);
            end
        end
        checks++;
        if (u_if.pc !== 32'd16 || u_if.fetch_cnt !== 16'd4 || u_if.pc_plus4 !== 32'd20) begin
            failures++;
            $display("FAIL seq_final got pc=%h cnt=%0d p4=%h want pc=10 cnt=4 p4=14",
                     u_if.pc, u_if.fetch_cnt, u_if.pc_plus4);
        end
    endtask

    task automatic test_branch();
        exp_t        e;
        logic [15:0] offs[2];
        logic [31:0] want[2];
        offs[0] = 16'hFFFE; want[0] = 32'h0000_00FC;
        offs[1] = 16'h0003; want[1] = 32'h0000_0110;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(0, 1, 1, 32'h100, 0, 0, 0, 0);
            e = sb_q.pop_front();
            drive_cycle(0, 1, 0, 0, 0, 0, 1, offs[i]);
            e = sb_q.pop_front();
            checks++;
            if (u_if.pc !== e.pc || u_if.pc !== want[i]) begin
                failures++;
                $display("FAIL branch_%0d got=%h want=%h", i, u_if.pc, want[i]);
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        drive_cycle(0, 1, 1, 32'h2003, 1, 26'h3FF, 1, 16'h0010);
        e = sb_q.pop_front();
        checks++;
        if (u_if.pc !== e.pc || u_if.pc !== 32'h2000) begin
            failures++;
            $display("FAIL priority got=%h want=2000", u_if.pc);
        end
        drive_cycle(0, 1, 0, 0, 1, 26'h0000123, 1, 16'h0010);
        e = sb_q.pop_front();
        checks++;
        if (u_if.pc !== e.pc || u_if.pc !== 32'h0000_048C) begin
            failures++;
            $display("FAIL jump_over_branch got=%h want=0000048c", u_if.pc);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        drive_cycle(0, 1, 1, 32'h40, 0, 0, 0, 0);
        e = sb_q.pop_front();
        drive_cycle(1, 1, 0, 0, 1, 26'h10, 0, 0);
        e = sb_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (u_if.pc !== e.pc || u_if.redir_pend !== e.pend || u_if.pc !== 32'h40 ||
                u_if.redir_pend !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold_%0d got pc=%h pend=%b want pc=40 pend=1",
                         i, u_if.pc, u_if.redir_pend);
            end
            if (i < 3) begin
                drive_cycle(1, 1, 0, 0, 0, 0, 0, 0);
                e = sb_q.pop_front();
            end
        end
        drive_cycle(0, 1, 0, 0, 0, 0, 0, 0);
        e = sb_q.pop_front();
        checks++;
        if (u_if.pc !== e.pc || u_if.redir_pend !== 1'b0 || u_if.pc !== 32'h40) begin
            failures++;
            $display("FAIL bp_apply got pc=%h pend=%b want pc=40 pend=0",
                     u_if.pc, u_if.redir_pend);
        end
        // Newer redirect overwrites the latched one while imem_ready is low.
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 16'h0008);
        e = sb_q.pop_front();
        drive_cycle(0, 0, 1, 32'h0000_0A04, 0, 0, 0, 0);
        e = sb_q.pop_front();
        checks++;
        if (u_if.pc !== e.pc || u_if.redir_pend !== e.pend) begin
            failures++;
            $display("FAIL bp_latch2 got pc=%h pend=%b want pc=%h pend=%b",
                     u_if.pc, u_if.redir_pend, e.pc, e.pend);
        end
        drive_cycle(0, 1, 0, 0, 0, 0, 0, 0);
        e = sb_q.pop_front();
        checks++;
        if (u_if.pc !== e.pc || u_if.pc !== 32'h0000_0A04 || u_if.redir_pend !== 1'b0) begin
            failures++;
            $display("FAIL bp_overwrite got pc=%h pend=%b want pc=00000a04 pend=0",
                     u_if.pc, u_if.redir_pend);
        end
        drive_cycle(0, 1, 0, 0, 0, 0, 0, 0);
        e = sb_q.pop_front();
        checks++;
        if (u_if.pc !== e.pc || u_if.pc !== 32'h0000_0A08) begin
            failures++;
            $display("FAIL bp_after got=%h want=00000a08", u_if.pc);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        drive_cycle(0, 1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
        e = sb_q.pop_front();
        checks++;
        if (u_if.pc !== e.pc || u_if.pc_plus4 !== 32'h0) begin
            failures++;
            $display("FAIL wrap_setup got pc=%h p4=%h want pc=fffffffc p4=0",
                     u_if.pc, u_if.pc_plus4);
        end
        drive_cycle(0, 1, 0, 0, 0, 0, 0, 0);
        e = sb_q.pop_front();
        checks++;
        if (u_if.pc !== e.pc || u_if.pc !== 32'h0) begin
            failures++;
            $display("FAIL wrap got=%h want=0", u_if.pc);
        end
        checks++;
        if (u_if.fetch_cnt !== e.cnt) begin
            failures++;
            $display("FAIL cnt_running got=%0d want=%0d", u_if.fetch_cnt, e.cnt);
        end
    endtask

    task automatic test_saturation();
        int c;
        int want;
        rst2_n = 1'b0;
        #3;
        @(negedge clk);
        rst2_n = 1'b1;
        @(posedge clk);
        #1;
        c = 0;
        for (int i = 0; i < 5; i++) begin
            c = (c < 3) ? c + 1 : 3;
            sb2_q.push_back(c);
            @(posedge clk);
            #1;
            want = sb2_q.pop_front();
            checks++;
            if (int'(u_if2.fetch_cnt) !== want) begin
                failures++;
                $display("FAIL sat_%0d got=%0d want=%0d", i, u_if2.fetch_cnt, want);
            end
        end
        checks++;
        if (u_if2.fetch_cnt !== 2'd3 || u_if2.pc !== 32'd20) begin
            failures++;
            $display("FAIL sat_final got cnt=%0d pc=%h want cnt=3 pc=14",
                     u_if2.fetch_cnt, u_if2.pc);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive_cycle(1, 1, 0, 0, 1, 26'h55, 0, 0);
        e = sb_q.pop_front();
        checks++;
        if (u_if.redir_pend !== 1'b1 || u_if.redir_pend !== e.pend) begin
            failures++;
            $display("FAIL ar_pend got=%b want=1", u_if.redir_pend);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (u_if.pc !== 32'h0 || u_if.redir_pend !== 1'b0 || u_if.imem_req !== 1'b0 ||
            u_if.fetch_cnt !== 16'h0) begin
            failures++;
            $display("FAIL async_reset got pc=%h pend=%b req=%b cnt=%0d want 0/0/0/0",
                     u_if.pc, u_if.redir_pend, u_if.imem_req, u_if.fetch_cnt);
        end
        model_reset();
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(0, 1, 0, 0, 0, 0, 0, 0);
        e = sb_q.pop_front();
        drive_cycle(0, 1, 0, 0, 0, 0, 0, 0);
        e = sb_q.pop_front();
        checks++;
        if (u_if.pc !== e.pc || u_if.pc !== 32'h4 || u_if.redir_pend !== 1'b0) begin
            failures++;
            $display("FAIL ar_resume got pc=%h pend=%b want pc=4 pend=0",
                     u_if.pc, u_if.redir_pend);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst2_n   = 1'b0;
        u_if2.stall      = 1'b0;
        u_if2.imem_ready = 1'b1;
        u_if2.jump_reg   = 1'b0;
        u_if2.reg_target = 32'h0;
        u_if2.jump       = 1'b0;
        u_if2.jump_imm   = 26'h0;
        u_if2.br_taken   = 1'b0;
        u_if2.br_off     = 16'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_priority();
        test_backpressure();
        test_wrap();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/b_fetch_unit.md
B_FETCH_UNIT -- requirements
Module: b_fetch_unit

Interface
REQ-001 Parameter WIDTH, default 32: PC and address width in bits.
REQ-002 Parameter OP_W, default 6: opcode width; jump target field is WIDTH-OP_W bits.
REQ-003 Parameter IMM_W, default 16: branch offset width in bits.
REQ-004 Parameter RESET_VEC, default 0: PC value loaded on reset; must be a multiple of 4.
REQ-005 Parameter CNT_W, default 16: fetch counter width in bits.
REQ-006 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-low reset.
REQ-008 Port stall, input, 1: when 1, the PC does not advance.
REQ-009 Port br_taken, input, 1: branch-redirect request.
REQ-010 Port br_off, input, IMM_W: signed word offset for a branch.
REQ-011 Port jump, input, 1: pseudo-direct jump request.
REQ-012 Port jump_imm, input, WIDTH-OP_W: jump target field.
REQ-013 Port jump_reg, input, 1: register-indirect jump request.
REQ-014 Port reg_target, input, WIDTH: register jump address.
REQ-015 Port imem_ready, input, 1: instruction memory accepts the current request.
REQ-016 Port imem_req, output, 1: fetch request valid.
REQ-017 Port pc, output, WIDTH: current fetch address; this is the request address.
REQ-018 Port pc_plus4, output, WIDTH: pc+4 mod 2^WIDTH; this is the link value.
REQ-019 Port redir_pend, output, 1: a redirect is latched and not yet applied.
REQ-020 Port fetch_cnt, output, CNT_W: count of accepted fetches.

Function
REQ-021 The FSM shall have two states, BOOT and FETCH.
 - BOOT: imem_req=0; unconditional transition to FETCH on the next edge.
 - FETCH: imem_req=1; the FSM does not leave FETCH except by reset.
REQ-022 A fetch is accepted in a cycle when the state is FETCH, imem_ready=1 and stall=0; only an accepted fetch shall change pc.
REQ-023 The redirect target shall be selected by fixed priority jump_reg > jump > br_taken.
 - jump_reg: {reg_target[WIDTH-1:2], 2'b00}.
 - jump: {pc_plus4[WIDTH-1:WIDTH-OP_W+2], jump_imm, 2'b00}.
 - branch: pc_plus4 + (sign_extend(br_off) << 2), mod 2^WIDTH.
REQ-024 On an accepted fetch, pc shall load the first applicable source in this order:
 1. the redirect target presented in the same cycle;
 2. otherwise, the latched redirect target (then clear redir_pend);
 3. otherwise, pc_plus4.
REQ-025 A redirect presented in a non-accepting cycle (BOOT, stall=1, or imem_ready=0) shall latch its target and set redir_pend=1 on that edge; pc is unchanged.
REQ-026 A newer redirect shall overwrite an already-latched target.
REQ-027 While imem_req=1 and the fetch is not accepted, pc shall stay stable.
REQ-028 PC arithmetic shall wrap modulo 2^WIDTH with no error indication.
REQ-029 fetch_cnt shall increment by 1 on each accepted fetch and saturate at 2^CNT_W-1.
REQ-030 pc_plus4 shall be combinational from pc; all other outputs shall be registered or decoded from state.

Reset
REQ-031 reset=0 shall immediately force the following, independent of clk:
 - state BOOT;
 - pc=RESET_VEC;
 - redir_pend=0 and latched target=0;
 - fetch_cnt=0;
 - imem_req=0.
REQ-032 Reset asserted mid-operation shall discard any pending redirect and any unaccepted request.
REQ-033 After reset deasserts, the first rising edge shall move BOOT to FETCH, and imem_req shall rise in that cycle.

Verification
REQ-034 Sequential run: WIDTH=32, RESET_VEC=0, ready=1, stall=0 for 4 cycles after BOOT -> pc 0,4,8,12,16; fetch_cnt=4.
REQ-035 Branch at pc=0x100 with br_off=0xFFFE and stall=0 -> next pc=0xFC; with br_off=0x0003 -> next pc=0x110.
REQ-036 Priority: jump_reg=1 (reg_target=0x2003), jump=1 and br_taken=1 in the same accepted cycle -> pc=0x2000.
REQ-037 Redirect under backpressure:
 - stimulus: at pc=0x40, stall=1, jump=1, jump_imm=0x10 for one cycle; 3 idle stall cycles; then stall=0 with ready=1;
 - response: pc holds 0x40 with redir_pend=1; then pc=0x40 (0x10<<2, upper bits 0); redir_pend=0.
REQ-038 Wrap and saturation:
 - pc=0xFFFFFFFC with one accept -> pc=0;
 - CNT_W=2 with 5 accepts -> fetch_cnt=3.
REQ-039 Async reset mid-run: reset=0 between clock edges with redir_pend=1 -> pc=RESET_VEC, redir_pend=0 and imem_req=0 before the next edge.
